// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the TX engine and baud generator.
package uart_pkg;

  localparam int unsigned UART_MIN_DATA_BITS = 5;
  localparam int unsigned TX_DIV_WIDTH       = 16;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_EVEN  = 3'd1,
    PAR_ODD   = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } parity_mode_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP,
    TX_BREAK
  } tx_state_t;

  function automatic logic parity_bit(parity_mode_t mode, logic data_xor);
    case (mode)
      PAR_EVEN: return data_xor;
      PAR_ODD:  return ~data_xor;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Divisor counter: counts 0..div and ticks on the terminal count, then wraps.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = TX_DIV_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] cnt;

  // Tick is suppressed while held clear so a zero divisor cannot fire in idle.
  assign o_tick = !i_clr && (cnt == i_div);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr || o_tick) cnt <= '0;
    else                          cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pulls words over valid/ready and serialises them
// LSB-first with latched per-frame length, parity, stop bits and baud divisor.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned MAX_DATA_BITS = 9,
  parameter int unsigned DIV_WIDTH     = TX_DIV_WIDTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [3:0]               i_data_bits,
  input  logic [2:0]               i_parity_mode,
  input  logic                     i_two_stop,
  input  logic [DIV_WIDTH-1:0]     i_baud_div,
  input  logic                     i_break,
  input  logic [MAX_DATA_BITS-1:0] i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  tx_state_t                state;
  logic [MAX_DATA_BITS-1:0] shreg;
  logic [3:0]               nbits_q;
  logic [3:0]               bit_idx;
  logic                     par_en_q;
  logic                     par_q;
  logic                     two_stop_q;
  logic                     stop_idx;
  logic                     brk_q;
  logic [DIV_WIDTH-1:0]     div_q;

  logic                     tick;
  logic                     stop_end;
  logic                     accept;
  logic [3:0]               nbits_c;
  logic [MAX_DATA_BITS-1:0] mask_c;
  parity_mode_t             mode_c;
  logic                     par_en_c;
  logic                     par_c;

  uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (state == TX_IDLE),
    .i_div  (div_q),
    .o_tick (tick)
  );

  always_comb begin
    nbits_c = i_data_bits;
    if (i_data_bits < 4'(UART_MIN_DATA_BITS))  nbits_c = 4'(UART_MIN_DATA_BITS);
    else if (i_data_bits > 4'(MAX_DATA_BITS))  nbits_c = 4'(MAX_DATA_BITS);
    mask_c = '0;
    for (int unsigned i = 0; i < MAX_DATA_BITS; i++) mask_c[i] = (i < 32'(nbits_c));
    mode_c   = parity_mode_t'(i_parity_mode);
    par_en_c = mode_c inside {PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE};
    par_c    = parity_bit(mode_c, ^(i_data & mask_c));
  end

  assign stop_end     = (state == TX_STOP) && tick && (!two_stop_q || stop_idx);
  assign o_ready      = !i_rst && i_en && !i_break && ((state == TX_IDLE) || stop_end);
  assign accept       = i_valid && o_ready;
  assign o_frame_done = !i_rst && stop_end && !brk_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= TX_IDLE;
      o_tx       <= 1'b1;
      o_busy     <= 1'b0;
      shreg      <= '0;
      nbits_q    <= 4'(UART_MIN_DATA_BITS);
      bit_idx    <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      two_stop_q <= 1'b0;
      stop_idx   <= 1'b0;
      brk_q      <= 1'b0;
      div_q      <= '0;
    end else if (accept) begin
      // Covers both the idle accept and the gapless accept on the final stop tick.
      state      <= TX_START;
      o_tx       <= 1'b0;
      o_busy     <= 1'b1;
      shreg      <= i_data;
      nbits_q    <= nbits_c;
      par_en_q   <= par_en_c;
      par_q      <= par_c;
      two_stop_q <= i_two_stop;
      div_q      <= i_baud_div;
      brk_q      <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (i_en && i_break) begin
            state      <= TX_BREAK;
            o_tx       <= 1'b0;
            o_busy     <= 1'b1;
            two_stop_q <= i_two_stop;
            div_q      <= i_baud_div;
            brk_q      <= 1'b1;
          end
        end
        TX_START: begin
          if (tick) begin
            state   <= TX_DATA;
            o_tx    <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
          end
        end
        TX_DATA: begin
          if (tick) begin
            if (bit_idx == nbits_q - 4'd1) begin
              if (par_en_q) begin
                state <= TX_PARITY;
                o_tx  <= par_q;
              end else begin
                state    <= TX_STOP;
                o_tx     <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              o_tx    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end
        TX_PARITY: begin
          if (tick) begin
            state    <= TX_STOP;
            o_tx     <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        TX_STOP: begin
          if (stop_end) begin
            if (i_en && i_break) begin
              state <= TX_BREAK;
              o_tx  <= 1'b0;
              brk_q <= 1'b1;
            end else begin
              state  <= TX_IDLE;
              o_busy <= 1'b0;
            end
          end else if (tick) begin
            stop_idx <= 1'b1;
          end
        end
        TX_BREAK: begin
          if (tick && !i_break) begin
            state    <= TX_STOP;
            o_tx     <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        default: begin
          state  <= TX_IDLE;
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine with hand-computed frames.
module tb_uart_tx_engine;
  import uart_pkg::*;

  typedef struct {
    logic [8:0]  data;
    logic [3:0]  nb;
    logic [2:0]  mode;
    logic        two;
    logic [15:0] div;
  } word_t;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_en = 1'b0;
  logic [3:0]  i_data_bits = 4'd8;
  logic [2:0]  i_parity_mode = 3'd0;
  logic        i_two_stop = 1'b0;
  logic [15:0] i_baud_div = 16'd0;
  logic        i_break = 1'b0;
  logic [8:0]  i_data = 9'd0;
  logic        i_valid = 1'b0;
  logic        o_ready, o_tx, o_busy, o_frame_done;

  int n_checks = 0;
  int n_errors = 0;
  word_t words[16];
  int wr_cnt = 0;
  int head = 0;
  int acc_cnt = 0;

  uart_tx_engine #(.MAX_DATA_BITS(9), .DIV_WIDTH(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_data_bits(i_data_bits),
    .i_parity_mode(i_parity_mode), .i_two_stop(i_two_stop), .i_baud_div(i_baud_div),
    .i_break(i_break), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_tx(o_tx), .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  initial forever #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Show-ahead FIFO model: the head word stays on the inputs until accepted.
  always begin
    bit took;
    @(negedge i_clk);
    took = i_valid && o_ready;
    if (took) acc_cnt++;
    @(posedge i_clk);
    #1;
    if (took) head++;
    if (head < wr_cnt) begin
      i_valid       = 1'b1;
      i_data        = words[head].data;
      i_data_bits   = words[head].nb;
      i_parity_mode = words[head].mode;
      i_two_stop    = words[head].two;
      i_baud_div    = words[head].div;
    end else begin
      i_valid = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [8:0] data, input logic [3:0] nb, input logic [2:0] mode,
                      input logic two, input logic [15:0] div);
    words[wr_cnt] = '{data, nb, mode, two, div};
    wr_cnt++;
  endtask

  task automatic wait_start(input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge i_clk);
      found = o_busy;
    end
    check_eq({tag, "_start"}, 32'(found), 32'd1);
  endtask

  // Checks every clock of one frame starting at the current sample point.
  task automatic check_frame(input string tag, input logic [15:0] vec, input int len,
                             input int div, input bit done_exp);
    for (int b = 0; b < len; b++) begin
      for (int c = 0; c <= div; c++) begin
        if (b != 0 || c != 0) @(negedge i_clk);
        check_eq({tag, "_tx"}, 32'(o_tx), 32'(vec[b]));
        check_eq({tag, "_busy"}, 32'(o_busy), 32'd1);
        check_eq({tag, "_done"}, 32'(o_frame_done),
                 32'(done_exp && (b == len - 1) && (c == div)));
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge i_clk);
    check_eq({tag, "_idle_busy"}, 32'(o_busy), 32'd0);
    check_eq({tag, "_idle_tx"}, 32'(o_tx), 32'd1);
  endtask

  task automatic single(input string tag, input logic [8:0] data, input logic [3:0] nb,
                        input logic [2:0] mode, input logic [15:0] div,
                        input logic [15:0] vec, input int len);
    push(data, nb, mode, 1'b0, div);
    wait_start(tag);
    check_frame(tag, vec, len, int'(div), 1'b1);
    check_idle(tag);
  endtask

  initial begin
    int acc0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_eq("rst_tx", 32'(o_tx), 32'd1);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_ready", 32'(o_ready), 32'd0);
    check_eq("rst_done", 32'(o_frame_done), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_en  = 1'b1;
    @(negedge i_clk);
    check_eq("idle_ready", 32'(o_ready), 32'd1);
    check_eq("idle_tx", 32'(o_tx), 32'd1);

    // 0x55, 8N1, 4 clocks per bit
    single("t1_55", 9'h055, 4'd8, PAR_NONE, 16'd3, 16'h02AA, 10);

    // parity modes; 0x087 has bit 7 outside the 7-bit field
    single("t2_even", 9'h087, 4'd7, PAR_EVEN,  16'd0, 16'h030E, 10);
    single("t2_odd",  9'h087, 4'd7, PAR_ODD,   16'd0, 16'h020E, 10);
    single("t2_mark", 9'h007, 4'd7, PAR_MARK,  16'd0, 16'h030E, 10);
    single("t2_space",9'h007, 4'd7, PAR_SPACE, 16'd0, 16'h020E, 10);
    single("t2_9even",9'h1FF, 4'd9, PAR_EVEN,  16'd0, 16'h0FFE, 12);

    // three queued words, 8E2, gapless
    acc0 = acc_cnt;
    push(9'h0A1, 4'd8, PAR_EVEN, 1'b1, 16'd1);
    push(9'h0B2, 4'd8, PAR_EVEN, 1'b1, 16'd1);
    push(9'h0C3, 4'd8, PAR_EVEN, 1'b1, 16'd1);
    wait_start("t3");
    check_frame("t3_a1", 16'h0F42, 12, 1, 1'b1);
    @(negedge i_clk);
    check_frame("t3_b2", 16'h0D64, 12, 1, 1'b1);
    @(negedge i_clk);
    check_frame("t3_c3", 16'h0D86, 12, 1, 1'b1);
    check_idle("t3");
    check_eq("t3_accepts", 32'(acc_cnt - acc0), 32'd3);

    // data length clamping
    single("t4_clamp5", 9'h03A, 4'd2,  PAR_NONE, 16'd0, 16'h0074, 7);
    single("t4_clamp9", 9'h100, 4'd12, PAR_NONE, 16'd0, 16'h0600, 11);

    // divisor presented as 7 during the first frame only applies to the next
    push(9'h055, 4'd8, PAR_NONE, 1'b0, 16'd3);
    push(9'h055, 4'd8, PAR_NONE, 1'b0, 16'd7);
    wait_start("t4_div");
    check_frame("t4_div3", 16'h02AA, 10, 3, 1'b1);
    @(negedge i_clk);
    check_frame("t4_div7", 16'h02AA, 10, 7, 1'b1);
    check_idle("t4_div");

    // break requested mid-frame
    push(9'h03C, 4'd8, PAR_NONE, 1'b0, 16'd1);
    wait_start("t5");
    fork
      check_frame("t5_frame", 16'h0278, 10, 1, 1'b1);
      begin
        repeat (6) @(posedge i_clk);
        #1 i_break = 1'b1;
      end
    join
    for (int j = 1; j <= 8; j++) begin
      @(negedge i_clk);
      check_eq("t5_brk_tx", 32'(o_tx), (j <= 4) ? 32'd0 : 32'd1);
      check_eq("t5_brk_busy", 32'(o_busy), (j <= 6) ? 32'd1 : 32'd0);
      check_eq("t5_brk_done", 32'(o_frame_done), 32'd0);
      if (j == 7) check_eq("t5_brk_ready", 32'(o_ready), 32'd1);
      if (j == 3) begin
        @(posedge i_clk); #1;
        i_break = 1'b0;
      end
    end

    // reset during data bit 3 of an all-zero word
    push(9'h000, 4'd8, PAR_NONE, 1'b0, 16'd1);
    wait_start("t6");
    repeat (8) @(negedge i_clk);
    check_eq("t6_pre_tx", 32'(o_tx), 32'd0);
    check_eq("t6_pre_busy", 32'(o_busy), 32'd1);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check_eq("t6_rst_tx", 32'(o_tx), 32'd1);
    check_eq("t6_rst_busy", 32'(o_busy), 32'd0);
    check_eq("t6_rst_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    single("t6_fresh", 9'h05A, 4'd8, PAR_ODD, 16'd0, 16'h06B4, 11);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
